// File: rtl/regfile_mp.sv
// Parametrised multi-port register file for the CPU datapath.
// Registered reads with per-port enable and hold, prioritised multi-port
// writes with conflict reporting, synchronous bulk clear, optional hardwired
// zero register, and a selectable read-first / write-first bypass.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic [NUM_RD-1:0]        re_i,
  input  logic [NUM_RD*ADDR_W-1:0] ra_i,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*ADDR_W-1:0] wa_i,
  input  logic [NUM_WR*DATA_W-1:0] din_i,
  output logic [NUM_RD*DATA_W-1:0] rd_o,
  output logic                     wr_conflict_o
);

  localparam int DEPTH = 1 << ADDR_W;

  // Port counts outside the supported range stop elaboration.
  generate
    if (NUM_RD < 1 || NUM_RD > 4 || NUM_WR < 1 || NUM_WR > 2) begin : g_bad_params
      $error("regfile_mp: NUM_RD must be 1..4 and NUM_WR must be 1..2");
    end
  endgenerate

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_q  [NUM_RD];
  logic [DATA_W-1:0] rd_d  [NUM_RD];
  logic              wr_conflict_q;
  logic              wr_conflict_d;
  logic [NUM_WR-1:0] wr_valid;

  // A write is effective unless it targets the hardwired zero register.
  always_comb begin
    wr_valid = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_valid[j] = we_i[j] &&
                    !((ZERO_REG != 0) && (wa_i[j*ADDR_W +: ADDR_W] == '0));
    end
  end

  // Next array contents: clear wins, otherwise higher-indexed ports overwrite lower ones.
  always_comb begin
    mem_d = mem_q;
    if (clr_i) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_d[r] = '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_valid[j]) begin
          mem_d[wa_i[j*ADDR_W +: ADDR_W]] = din_i[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Flag any pair of effective writes hitting the same address; a clear discards them all.
  always_comb begin
    wr_conflict_d = 1'b0;
    if (!clr_i) begin
      for (int j = 0; j < NUM_WR; j++) begin
        for (int k = j + 1; k < NUM_WR; k++) begin
          if (wr_valid[j] && wr_valid[k] &&
              (wa_i[j*ADDR_W +: ADDR_W] == wa_i[k*ADDR_W +: ADDR_W])) begin
            wr_conflict_d = 1'b1;
          end
        end
      end
    end
  end

  // Per-port read value: array (or forwarded write data in write-first mode), zeroed by clear or r0, held when disabled.
  always_comb begin
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rval;
    raddr = '0;
    rval  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      raddr = ra_i[i*ADDR_W +: ADDR_W];
      rval  = mem_q[raddr];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_valid[j] && (wa_i[j*ADDR_W +: ADDR_W] == raddr)) begin
            rval = din_i[j*DATA_W +: DATA_W];
          end
        end
      end
      if (clr_i || ((ZERO_REG != 0) && (raddr == '0))) begin
        rval = '0;
      end
      rd_d[i] = re_i[i] ? rval : rd_q[i];
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      for (int i = 0; i < NUM_RD; i++) begin
        rd_q[i] <= '0;
      end
      wr_conflict_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      rd_q          <= rd_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_pack
      assign rd_o[i*DATA_W +: DATA_W] = rd_q[i];
    end
  endgenerate

  assign wr_conflict_o = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: two instances share stimulus, one
// read-first and one write-first, both with two read and two write ports.
// A behavioural model queues expected outputs per edge; each test task
// pops and compares them, plus fixed values from the test plan.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             clr;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] ra;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wa;
  logic [NW*DW-1:0] din;
  logic [NR*DW-1:0] rdA, rdB;
  logic             confA, confB;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
               .ZERO_REG(1), .BYPASS(0)) dutRf (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .re_i(re), .ra_i(ra),
    .we_i(we), .wa_i(wa), .din_i(din), .rd_o(rdA), .wr_conflict_o(confA));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
               .ZERO_REG(1), .BYPASS(1)) dutBp (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .re_i(re), .ra_i(ra),
    .we_i(we), .wa_i(wa), .din_i(din), .rd_o(rdB), .wr_conflict_o(confB));

  typedef struct {
    string            tag;
    logic [NR*DW-1:0] rdA;
    logic [NR*DW-1:0] rdB;
    logic             confA;
    logic             confB;
  } exp_t;

  exp_t expQ[$];
  exp_t e;
  int   passCount  = 0;
  int   checkCount = 0;

  logic [DW-1:0]    mMem [32];
  logic [NR*DW-1:0] mRdA, mRdB;
  logic             mConf;

  task automatic setRead(input int i, input logic en, input logic [AW-1:0] a);
    re[i] = en;
    ra[i*AW +: AW] = a;
  endtask

  task automatic setWrite(input int j, input logic en, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    we[j] = en;
    wa[j*AW +: AW] = a;
    din[j*DW +: DW] = d;
  endtask

  task automatic idle();
    clr = 1'b0;
    re  = '0;
    ra  = '0;
    we  = '0;
    wa  = '0;
    din = '0;
  endtask

  task automatic modelReset();
    for (int r = 0; r < 32; r++) mMem[r] = '0;
    mRdA  = '0;
    mRdB  = '0;
    mConf = 1'b0;
  endtask

  // Computes the expected post-edge outputs from the current inputs, queues them, then advances one edge.
  task automatic tick(input string tag);
    exp_t          x;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    for (int i = 0; i < NR; i++) begin
      if (re[i]) begin
        a = ra[i*AW +: AW];
        v = mMem[a];
        if (clr || a == 0) v = '0;
        mRdA[i*DW +: DW] = v;
        v = mMem[a];
        for (int j = 0; j < NW; j++)
          if (we[j] && wa[j*AW +: AW] == a) v = din[j*DW +: DW];
        if (clr || a == 0) v = '0;
        mRdB[i*DW +: DW] = v;
      end
    end
    mConf = !clr && (we == 2'b11) && (wa[0 +: AW] == wa[AW +: AW]) && (wa[0 +: AW] != 0);
    if (clr) begin
      for (int r = 0; r < 32; r++) mMem[r] = '0;
    end else begin
      for (int j = 0; j < NW; j++)
        if (we[j] && wa[j*AW +: AW] != 0) mMem[wa[j*AW +: AW]] = din[j*DW +: DW];
    end
    x.tag = tag; x.rdA = mRdA; x.rdB = mRdB; x.confA = mConf; x.confB = mConf;
    expQ.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checkCount++;
    if ({rdA, rdB, confA, confB} === '0) passCount++;
    else $display("[TB] FAIL reset_state: got %h %h %b %b expected all zero", rdA, rdB, confA, confB);
    rst_n = 1'b1;

    idle(); setWrite(0, 1'b1, 5'd5, 32'hDEADBEEF); tick("rst_load");
    e = expQ.pop_front();
    checkCount += 2;
    if ({rdA, confA} === {e.rdA, e.confA}) passCount++;
    else $display("[TB] FAIL %s_rf: got %h/%b expected %h/%b", e.tag, rdA, confA, e.rdA, e.confA);
    if ({rdB, confB} === {e.rdB, e.confB}) passCount++;
    else $display("[TB] FAIL %s_bp: got %h/%b expected %h/%b", e.tag, rdB, confB, e.rdB, e.confB);

    idle(); setRead(0, 1'b1, 5'd5); tick("rst_read5");
    e = expQ.pop_front();
    checkCount += 2;
    if ({rdA, confA} === {e.rdA, e.confA}) passCount++;
    else $display("[TB] FAIL %s_rf: got %h/%b expected %h/%b", e.tag, rdA, confA, e.rdA, e.confA);
    if (rdA[31:0] === 32'hDEADBEEF) passCount++;
    else $display("[TB] FAIL rst_pre_value: got %h expected deadbeef", rdA[31:0]);

    idle();
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if ({rdA, rdB, confA, confB} === '0) passCount++;
    else $display("[TB] FAIL rst_async: got %h %h expected zero", rdA, rdB);
    modelReset();
    #1 rst_n = 1'b1;

    setRead(0, 1'b1, 5'd5); tick("rst_after");
    e = expQ.pop_front();
    checkCount += 2;
    if ({rdB, confB} === {e.rdB, e.confB}) passCount++;
    else $display("[TB] FAIL %s_bp: got %h/%b expected %h/%b", e.tag, rdB, confB, e.rdB, e.confB);
    if (rdA[31:0] === 32'h0) passCount++;
    else $display("[TB] FAIL rst_r5_cleared: got %h expected 00000000", rdA[31:0]);
  endtask

  task automatic test_latency();
    idle(); setWrite(0, 1'b1, 5'd3, 32'h12345678); setWrite(1, 1'b1, 5'd7, 32'hCAFEF00D);
    tick("lat_write");
    e = expQ.pop_front();
    checkCount++;
    if ({rdA, confA} === {e.rdA, e.confA}) passCount++;
    else $display("[TB] FAIL %s_rf: got %h/%b expected %h/%b", e.tag, rdA, confA, e.rdA, e.confA);

    idle(); setRead(0, 1'b1, 5'd3); tick("lat_read");
    e = expQ.pop_front();
    checkCount += 2;
    if ({rdB, confB} === {e.rdB, e.confB}) passCount++;
    else $display("[TB] FAIL %s_bp: got %h/%b expected %h/%b", e.tag, rdB, confB, e.rdB, e.confB);
    if (rdA[31:0] === 32'h12345678) passCount++;
    else $display("[TB] FAIL lat_value: got %h expected 12345678", rdA[31:0]);

    idle(); setRead(0, 1'b0, 5'd7); setRead(1, 1'b1, 5'd3); tick("lat_hold");
    e = expQ.pop_front();
    checkCount += 3;
    if ({rdA, confA} === {e.rdA, e.confA}) passCount++;
    else $display("[TB] FAIL %s_rf: got %h/%b expected %h/%b", e.tag, rdA, confA, e.rdA, e.confA);
    if (rdB[31:0] === 32'h12345678) passCount++;
    else $display("[TB] FAIL lat_hold_port0: got %h expected 12345678", rdB[31:0]);
    if (rdA[63:32] === 32'h12345678) passCount++;
    else $display("[TB] FAIL lat_port1: got %h expected 12345678", rdA[63:32]);
  endtask

  task automatic test_bypass();
    idle(); setWrite(0, 1'b1, 5'd4, 32'h11111111); tick("byp_old");
    e = expQ.pop_front();
    checkCount++;
    if ({rdB, confB} === {e.rdB, e.confB}) passCount++;
    else $display("[TB] FAIL %s_bp: got %h/%b expected %h/%b", e.tag, rdB, confB, e.rdB, e.confB);

    idle(); setWrite(0, 1'b1, 5'd4, 32'hAAAA5555); setRead(0, 1'b1, 5'd4); tick("byp_same");
    e = expQ.pop_front();
    checkCount += 4;
    if ({rdA, confA} === {e.rdA, e.confA}) passCount++;
    else $display("[TB] FAIL %s_rf: got %h/%b expected %h/%b", e.tag, rdA, confA, e.rdA, e.confA);
    if ({rdB, confB} === {e.rdB, e.confB}) passCount++;
    else $display("[TB] FAIL %s_bp: got %h/%b expected %h/%b", e.tag, rdB, confB, e.rdB, e.confB);
    if (rdA[31:0] === 32'h11111111) passCount++;
    else $display("[TB] FAIL byp_read_first: got %h expected 11111111", rdA[31:0]);
    if (rdB[31:0] === 32'hAAAA5555) passCount++;
    else $display("[TB] FAIL byp_write_first: got %h expected aaaa5555", rdB[31:0]);

    idle(); setRead(0, 1'b1, 5'd4); tick("byp_next");
    e = expQ.pop_front();
    checkCount++;
    if (rdA[31:0] === 32'hAAAA5555) passCount++;
    else $display("[TB] FAIL byp_next: got %h expected aaaa5555", rdA[31:0]);
  endtask

  task automatic test_conflict();
    idle(); setWrite(0, 1'b1, 5'd9, 32'h1); setWrite(1, 1'b1, 5'd9, 32'h2);
    setRead(1, 1'b1, 5'd9); tick("cfl_write");
    e = expQ.pop_front();
    checkCount += 4;
    if ({rdA, confA} === {e.rdA, e.confA}) passCount++;
    else $display("[TB] FAIL %s_rf: got %h/%b expected %h/%b", e.tag, rdA, confA, e.rdA, e.confA);
    if ({rdB, confB} === {e.rdB, e.confB}) passCount++;
    else $display("[TB] FAIL %s_bp: got %h/%b expected %h/%b", e.tag, rdB, confB, e.rdB, e.confB);
    if ({confA, confB} === 2'b11) passCount++;
    else $display("[TB] FAIL cfl_flag: got %b%b expected 11", confA, confB);
    if (rdB[63:32] === 32'h2) passCount++;
    else $display("[TB] FAIL cfl_forward: got %h expected 00000002", rdB[63:32]);

    idle(); setRead(0, 1'b1, 5'd9); setWrite(0, 1'b1, 5'd10, 32'h3); setWrite(1, 1'b1, 5'd11, 32'h4);
    tick("cfl_after");
    e = expQ.pop_front();
    checkCount += 3;
    if ({rdA, confA} === {e.rdA, e.confA}) passCount++;
    else $display("[TB] FAIL %s_rf: got %h/%b expected %h/%b", e.tag, rdA, confA, e.rdA, e.confA);
    if (rdA[31:0] === 32'h2) passCount++;
    else $display("[TB] FAIL cfl_winner: got %h expected 00000002", rdA[31:0]);
    if ({confA, confB} === 2'b00) passCount++;
    else $display("[TB] FAIL cfl_one_cycle: got %b%b expected 00", confA, confB);

    idle(); setRead(0, 1'b1, 5'd10); setRead(1, 1'b1, 5'd11); tick("cfl_distinct");
    e = expQ.pop_front();
    checkCount++;
    if ({rdB, confB} === {e.rdB, e.confB}) passCount++;
    else $display("[TB] FAIL %s_bp: got %h/%b expected %h/%b", e.tag, rdB, confB, e.rdB, e.confB);
  endtask

  task automatic test_zero();
    idle(); setWrite(0, 1'b1, 5'd0, 32'hFFFFFFFF); setWrite(1, 1'b1, 5'd0, 32'h12345678);
    setRead(0, 1'b1, 5'd0); tick("zero_write");
    e = expQ.pop_front();
    checkCount += 3;
    if ({rdB, confB} === {e.rdB, e.confB}) passCount++;
    else $display("[TB] FAIL %s_bp: got %h/%b expected %h/%b", e.tag, rdB, confB, e.rdB, e.confB);
    if (rdB[31:0] === 32'h0) passCount++;
    else $display("[TB] FAIL zero_bypass: got %h expected 00000000", rdB[31:0]);
    if ({confA, confB} === 2'b00) passCount++;
    else $display("[TB] FAIL zero_conflict: got %b%b expected 00", confA, confB);

    idle(); setRead(0, 1'b1, 5'd0); setRead(1, 1'b1, 5'd0); tick("zero_read");
    e = expQ.pop_front();
    checkCount += 2;
    if ({rdA, confA} === {e.rdA, e.confA}) passCount++;
    else $display("[TB] FAIL %s_rf: got %h/%b expected %h/%b", e.tag, rdA, confA, e.rdA, e.confA);
    if (rdA === '0) passCount++;
    else $display("[TB] FAIL zero_stored: got %h expected 0", rdA);
  endtask

  task automatic test_clear();
    idle(); setWrite(0, 1'b1, 5'd1, 32'h5); setWrite(1, 1'b1, 5'd2, 32'h6); tick("clr_load");
    e = expQ.pop_front();

    idle(); setRead(0, 1'b1, 5'd1); setRead(1, 1'b1, 5'd2); tick("clr_pre");
    e = expQ.pop_front();
    checkCount += 2;
    if ({rdA, confA} === {e.rdA, e.confA}) passCount++;
    else $display("[TB] FAIL %s_rf: got %h/%b expected %h/%b", e.tag, rdA, confA, e.rdA, e.confA);
    if (rdB === {32'h6, 32'h5}) passCount++;
    else $display("[TB] FAIL clr_pre_values: got %h expected 0000000600000005", rdB);

    idle(); clr = 1'b1; setWrite(0, 1'b1, 5'd1, 32'h7); setRead(0, 1'b1, 5'd1); tick("clr_edge");
    e = expQ.pop_front();
    checkCount += 3;
    if ({rdA, confA} === {e.rdA, e.confA}) passCount++;
    else $display("[TB] FAIL %s_rf: got %h/%b expected %h/%b", e.tag, rdA, confA, e.rdA, e.confA);
    if ({rdB, confB} === {e.rdB, e.confB}) passCount++;
    else $display("[TB] FAIL %s_bp: got %h/%b expected %h/%b", e.tag, rdB, confB, e.rdB, e.confB);
    if ({rdA[31:0], rdB[31:0]} === 64'h0) passCount++;
    else $display("[TB] FAIL clr_read_zero: got %h %h expected 0", rdA[31:0], rdB[31:0]);

    idle(); clr = 1'b1; setWrite(0, 1'b1, 5'd12, 32'h8); setWrite(1, 1'b1, 5'd12, 32'h9); tick("clr_conflict");
    e = expQ.pop_front();
    checkCount++;
    if ({confA, confB} === 2'b00) passCount++;
    else $display("[TB] FAIL clr_no_conflict: got %b%b expected 00", confA, confB);

    idle(); setRead(0, 1'b1, 5'd1); setRead(1, 1'b1, 5'd2); tick("clr_after");
    e = expQ.pop_front();
    checkCount += 3;
    if ({rdA, confA} === {e.rdA, e.confA}) passCount++;
    else $display("[TB] FAIL %s_rf: got %h/%b expected %h/%b", e.tag, rdA, confA, e.rdA, e.confA);
    if ({rdB, confB} === {e.rdB, e.confB}) passCount++;
    else $display("[TB] FAIL %s_bp: got %h/%b expected %h/%b", e.tag, rdB, confB, e.rdB, e.confB);
    if ({rdA, rdB} === '0) passCount++;
    else $display("[TB] FAIL clr_regs_zero: got %h %h expected 0", rdA, rdB);
  endtask

  initial begin
    modelReset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_bypass();
    test_conflict();
    test_zero();
    test_clear();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the CPU datapath.
- Next generation of the 2-read/1-write register file: configurable data width, depth, read-port count and write-port count.
- Adds asynchronous reset, a synchronous bulk clear, per-port read enables with output hold, deterministic write-conflict priority, an optional hardwired zero register, and a selectable write-to-read bypass mode.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
- DATA_W, 32, bits per register
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 1, number of write ports (1..2)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 0, 0 = read-first (old data returned on same-cycle write), 1 = write-first (new data forwarded)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of all registers
- re  in  NUM_RD  per-read-port enable
- ra  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- we  in  NUM_WR  per-write-port enable
- wa  in  NUM_WR*ADDR_W  write addresses, packed as ra
- din  in  NUM_WR*DATA_W  write data, packed likewise
- rd  out  NUM_RD*DATA_W  registered read data, packed likewise
- wr_conflict  out  1  registered flag: two enabled write ports targeted the same address last cycle

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all rd = 0, wr_conflict = 0. Takes effect immediately, mid-operation included. The first edge after deassertion behaves normally.
- Read latency: 1 cycle. At a clk rising edge with re[i]=1, rd[i] is loaded from ra[i]. With re[i]=0, rd[i] holds its previous value.
- Write: at a clk rising edge, each port j with we[j]=1 writes din[j] to wa[j].
- Write priority: if ports j<k both write the same address, port k (highest index) wins. wr_conflict = 1 on the following cycle; otherwise 0.
- ZERO_REG=1:
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0, including through the bypass path.
  - Writes to address 0 do not raise wr_conflict.
- BYPASS=0: a read and a write to the same address at the same edge returns the pre-write value. The new value is visible from the next read.
- BYPASS=1: a same-edge matching read returns the winning write's din. Write priority applies to the forwarded value.
- clr=1 at an edge:
  - All registers become 0.
  - Reads at that edge return 0.
  - Writes at that edge are discarded, so clr beats we.
  - wr_conflict is 0 on the next cycle.
- Out-of-range parameters (NUM_RD>4, NUM_WR>2) are rejected at elaboration.
- Reads and writes to different addresses are fully independent; any port combination may be active in one cycle.

Test Plan:
- Reset: load r5=0xDEADBEEF, pulse rst_n low between edges -> rd drops to 0 immediately; a read of r5 after release returns 0x00000000.
- Basic/latency: write r3=0x12345678 at edge N, re0=1 ra0=3 at edge N+1 -> rd0=0x12345678 after N+1. Drop re0 and change ra0 to 7 -> rd0 holds 0x12345678.
- Bypass: same-edge write r4=0xAAAA5555 (old 0x11111111) and read r4 -> BYPASS=0: rd=0x11111111; BYPASS=1: rd=0xAAAA5555.
- Conflict (NUM_WR=2): both ports write r9, din0=0x1, din1=0x2 -> r9 reads 0x2; wr_conflict=1 for exactly one cycle.
- Zero register: write r0=0xFFFFFFFF with bypass on, same-edge read r0 -> rd=0; subsequent read of r0 = 0; wr_conflict=0.
- Clear: r1=0x5, r2=0x6, assert clr together with a write r1=0x7 -> r1 and r2 both read 0 afterwards.
